// File: rtl/regfile_port_sequencer.sv
// Register-file port sequencer.
// This block owns the single write port and both read-address ports of a 2**D x W register file.
// It serves two requesters: a core command port (READ/WRITE/SWAP) and a memory load-return port.
// When a write-class command and a load return both want the write port, round-robin arbitration picks one.
// SWAP is issued as two back-to-back writes.
// A read made in the same cycle as a registered write to the same register sees the write data through the bypass.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | accepting requests; arbitrates write-port conflicts
//   SWAP_WB | issuing the second SWAP write (rb <= va); both ports stalled
module regfile_port_sequencer #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [1:0]   cmd_op_i,
  input  logic [D-1:0] cmd_ra_i,
  input  logic [D-1:0] cmd_rb_i,
  input  logic [W-1:0] cmd_wdata_i,
  input  logic         ld_valid_i,
  output logic         ld_ready_o,
  input  logic [D-1:0] ld_addr_i,
  input  logic [W-1:0] ld_data_i,
  output logic [D-1:0] rf_raddr_a_o,
  output logic [D-1:0] rf_raddr_b_o,
  input  logic [W-1:0] rf_rdata_a_i,
  input  logic [W-1:0] rf_rdata_b_i,
  output logic         rf_we_o,
  output logic [D-1:0] rf_waddr_o,
  output logic [W-1:0] rf_wdata_o,
  output logic         rsp_valid_o,
  output logic [W-1:0] rsp_a_o,
  output logic [W-1:0] rsp_b_o
);

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic {ST_IDLE, ST_SWAP_WB} state_t;

  state_t       state_q;
  logic         prio_q;
  logic         rf_we_q;
  logic [D-1:0] rf_waddr_q;
  logic [W-1:0] rf_wdata_q;
  logic         rsp_valid_q;
  logic [W-1:0] rsp_a_q;
  logic [W-1:0] rsp_b_q;
  logic [D-1:0] sw_addr_q;
  logic [W-1:0] sw_data_q;

  logic         cmd_is_wr;
  logic         conflict;
  logic         accepting;
  logic         prio_d;
  logic         cmd_acc;
  logic         ld_acc;
  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;

  assign rf_raddr_a_o = cmd_ra_i;
  assign rf_raddr_b_o = cmd_rb_i;
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_a_o      = rsp_a_q;
  assign rsp_b_o      = rsp_b_q;

  // Handshake, arbitration and write-data bypass; only the bit op[1] separates write-class ops.
  always_comb begin
    cmd_is_wr   = cmd_valid_i && cmd_op_i[1];
    conflict    = cmd_is_wr && ld_valid_i;
    accepting   = (state_q == ST_IDLE) && !reset_i;
    cmd_ready_o = accepting && !(conflict && prio_q);
    ld_ready_o  = accepting && (!cmd_is_wr || prio_q);
    prio_d      = (accepting && conflict) ? !prio_q : prio_q;
    cmd_acc     = cmd_valid_i && cmd_ready_o;
    ld_acc      = ld_valid_i && ld_ready_o;
    fwd_a       = (rf_we_q && (rf_waddr_q == cmd_ra_i)) ? rf_wdata_q : rf_rdata_a_i;
    fwd_b       = (rf_we_q && (rf_waddr_q == cmd_rb_i)) ? rf_wdata_q : rf_rdata_b_i;
  end

  // Sequencer FSM with registered write-port and response outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      sw_addr_q   <= '0;
      sw_data_q   <= '0;
    end else begin
      rf_we_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      prio_q      <= prio_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_acc) begin
            case (cmd_op_i)
              OP_READ: begin
                rsp_valid_q <= 1'b1;
                rsp_a_q     <= fwd_a;
                rsp_b_q     <= fwd_b;
              end
              OP_WRITE: begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= cmd_ra_i;
                rf_wdata_q <= cmd_wdata_i;
              end
              OP_SWAP: begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= cmd_ra_i;
                rf_wdata_q <= fwd_b;
                sw_addr_q  <= cmd_rb_i;
                sw_data_q  <= fwd_a;
                state_q    <= ST_SWAP_WB;
              end
              default: ;
            endcase
          end
          // The arbiter never grants a load alongside a write-class command.
          if (ld_acc) begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= ld_addr_i;
            rf_wdata_q <= ld_data_i;
          end
        end
        ST_SWAP_WB: begin
          rf_we_q    <= 1'b1;
          rf_waddr_q <= sw_addr_q;
          rf_wdata_q <= sw_data_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Testbench for regfile_port_sequencer.
// The bench holds a register-file array that the DUT drives.
// The reference model tracks architectural register contents: each accepted operation takes effect at once for later operations.
// A read accepted in the same cycle as a load sees the value from before that load.
// From this model the bench predicts the handshakes, the write-port traffic and the read responses.
module tb_regfile_port_sequencer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int NR = 1 << D;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [D-1:0] cmd_ra, cmd_rb;
  logic [W-1:0] cmd_wdata;
  logic         ld_valid, ld_ready;
  logic [D-1:0] ld_addr;
  logic [W-1:0] ld_data;
  logic [D-1:0] rf_raddr_a, rf_raddr_b;
  logic [W-1:0] rf_rdata_a, rf_rdata_b;
  logic         rf_we;
  logic [D-1:0] rf_waddr;
  logic [W-1:0] rf_wdata;
  logic         rsp_valid;
  logic [W-1:0] rsp_a, rsp_b;

  logic         preload;
  logic [W-1:0] env_mem [NR];
  logic [W-1:0] arch [NR];

  int n_checks = 0;
  int n_errors = 0;

  bit           m_prio, m_busy, m_cmd_acc, m_ld_acc;
  logic [D-1:0] m_sw_addr;
  logic [W-1:0] m_sw_data, m_sw_restore;
  bit           e_we, e_rsp, e_rst;
  logic [D-1:0] e_waddr;
  logic [W-1:0] e_wdata, e_a, e_b;

  always #5 clk = ~clk;

  regfile_port_sequencer #(.W(W), .D(D)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_ra_i(cmd_ra), .cmd_rb_i(cmd_rb), .cmd_wdata_i(cmd_wdata),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .rf_raddr_a_o(rf_raddr_a), .rf_raddr_b_o(rf_raddr_b),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rsp_valid_o(rsp_valid), .rsp_a_o(rsp_a), .rsp_b_o(rsp_b)
  );

  // Register file behind the DUT: loads its initial contents, then takes the DUT's writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NR; i++) env_mem[i] <= arch[i];
    end else if (rf_we) begin
      env_mem[rf_waddr] <= rf_wdata;
    end
  end

  assign rf_rdata_a = env_mem[rf_raddr_a];
  assign rf_rdata_b = env_mem[rf_raddr_b];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict at the negedge, then compare the registered outputs just after the posedge.
  task automatic cycle();
    bit cmd_wr, conflict, ecr, elr;
    logic [W-1:0] va, vb;
    @(negedge clk);
    e_we = 0; e_rsp = 0; e_rst = 0; m_cmd_acc = 0; m_ld_acc = 0;
    chk("raddr_a", int'(rf_raddr_a), int'(cmd_ra));
    chk("raddr_b", int'(rf_raddr_b), int'(cmd_rb));
    if (reset_i) begin
      chk("cmd_ready_in_reset", int'(cmd_ready), 0);
      chk("ld_ready_in_reset", int'(ld_ready), 0);
      if (m_busy) arch[m_sw_addr] = m_sw_restore;
      m_busy = 0; m_prio = 0; e_rst = 1;
    end else if (m_busy) begin
      chk("cmd_ready_swap_wb", int'(cmd_ready), 0);
      chk("ld_ready_swap_wb", int'(ld_ready), 0);
      e_we = 1; e_waddr = m_sw_addr; e_wdata = m_sw_data;
      m_busy = 0;
    end else begin
      cmd_wr   = cmd_valid && (cmd_op == OP_WRITE || cmd_op == OP_SWAP);
      conflict = cmd_wr && ld_valid;
      ecr      = !(conflict && m_prio);
      elr      = !conflict || m_prio;
      if (cmd_valid) chk("cmd_ready", int'(cmd_ready), int'(ecr));
      if (ld_valid)  chk("ld_ready", int'(ld_ready), int'(elr));
      m_cmd_acc = cmd_valid && ecr;
      m_ld_acc  = ld_valid && elr;
      if (conflict) m_prio = !m_prio;
      if (m_cmd_acc) begin
        case (cmd_op)
          OP_READ: begin
            e_rsp = 1; e_a = arch[cmd_ra]; e_b = arch[cmd_rb];
          end
          OP_WRITE: begin
            arch[cmd_ra] = cmd_wdata;
            e_we = 1; e_waddr = cmd_ra; e_wdata = cmd_wdata;
          end
          OP_SWAP: begin
            va = arch[cmd_ra]; vb = arch[cmd_rb];
            arch[cmd_ra] = vb; arch[cmd_rb] = va;
            e_we = 1; e_waddr = cmd_ra; e_wdata = vb;
            m_busy = 1; m_sw_addr = cmd_rb; m_sw_data = va; m_sw_restore = vb;
          end
          default: ;
        endcase
      end
      if (m_ld_acc) begin
        arch[ld_addr] = ld_data;
        e_we = 1; e_waddr = ld_addr; e_wdata = ld_data;
      end
    end
    @(posedge clk);
    #1;
    chk("rf_we", int'(rf_we), int'(e_we));
    if (e_we) begin
      chk("rf_waddr", int'(rf_waddr), int'(e_waddr));
      chk("rf_wdata", int'(rf_wdata), int'(e_wdata));
    end
    chk("rsp_valid", int'(rsp_valid), int'(e_rsp));
    if (e_rsp) begin
      chk("rsp_a", int'(rsp_a), int'(e_a));
      chk("rsp_b", int'(rsp_b), int'(e_b));
    end
    if (e_rst) begin
      chk("rst_waddr", int'(rf_waddr), 0);
      chk("rst_wdata", int'(rf_wdata), 0);
      chk("rst_rsp_a", int'(rsp_a), 0);
      chk("rst_rsp_b", int'(rsp_b), 0);
    end
  endtask

  task automatic set_cmd(input logic v, input logic [1:0] op, input int ra, input int rb, input int wd);
    cmd_valid = v; cmd_op = op;
    cmd_ra = D'(ra); cmd_rb = D'(rb); cmd_wdata = W'(wd);
  endtask

  task automatic set_ld(input logic v, input int a, input int d);
    ld_valid = v; ld_addr = D'(a); ld_data = W'(d);
  endtask

  // Random stimulus that keeps a stalled request stable until the model says it was taken.
  task automatic drive_rand();
    if (!(cmd_valid && !m_cmd_acc))
      set_cmd(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
    if (!(ld_valid && !m_ld_acc))
      set_ld(($urandom_range(0, 9) < 4), $urandom_range(0, 7), $urandom_range(0, 255));
  endtask

  initial begin
    m_prio = 0; m_busy = 0; m_cmd_acc = 0; m_ld_acc = 0;
    for (int i = 0; i < NR; i++) arch[i] = W'($urandom);
    reset_i = 1'b1; preload = 1'b1;
    set_cmd(0, OP_NOP, 0, 0, 0);
    set_ld(0, 0, 0);
    cycle();
    preload = 1'b0;
    cycle();
    reset_i = 1'b0;

    // WRITE then an immediate READ of the same register through the bypass
    set_cmd(1, OP_WRITE, 3, 0, 'h5A); cycle();
    set_cmd(1, OP_READ, 3, 0, 0);     cycle();
    set_cmd(0, OP_NOP, 0, 0, 0);      cycle();

    // SWAP r1,r2 after loading them, then read both back
    set_cmd(1, OP_WRITE, 1, 0, 'h11); cycle();
    set_cmd(1, OP_WRITE, 2, 0, 'h22); cycle();
    set_cmd(1, OP_SWAP, 1, 2, 0);     cycle();
    set_cmd(1, OP_READ, 1, 2, 0);     cycle();
    cycle();
    set_cmd(0, OP_NOP, 0, 0, 0);      cycle();

    // Write-port conflict right after reset: grants alternate cmd, ld, cmd
    reset_i = 1'b1; cycle(); reset_i = 1'b0;
    set_cmd(1, OP_WRITE, 9, 0, 'hA1);
    set_ld(1, 10, 'hB2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (m_cmd_acc) cmd_wdata = cmd_wdata + 8'd1;
      if (m_ld_acc)  ld_data = ld_data + 8'd1;
    end
    set_cmd(0, OP_NOP, 0, 0, 0); set_ld(0, 0, 0); cycle();

    // READ and load accepted together
    set_cmd(1, OP_READ, 4, 5, 0); set_ld(1, 6, 'h77); cycle();
    set_cmd(1, OP_READ, 6, 4, 0); set_ld(0, 0, 0);    cycle();
    set_cmd(0, OP_NOP, 0, 0, 0); cycle();

    // Reset during SWAP_WB: the second write is dropped
    set_cmd(1, OP_SWAP, 1, 2, 0); cycle();
    set_cmd(0, OP_NOP, 0, 0, 0); reset_i = 1'b1; cycle();
    reset_i = 1'b0;
    set_cmd(1, OP_READ, 1, 2, 0); cycle();

    // SWAP of a register with itself
    set_cmd(1, OP_WRITE, 7, 0, 'h3C); cycle();
    set_cmd(1, OP_SWAP, 7, 7, 0);     cycle();
    set_cmd(0, OP_NOP, 0, 0, 0);      cycle();
    set_cmd(1, OP_READ, 7, 7, 0);     cycle();
    set_cmd(0, OP_NOP, 0, 0, 0);      cycle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      reset_i = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset_i = 1'b0;
    set_cmd(0, OP_NOP, 0, 0, 0); set_ld(0, 0, 0);
    cycle(); cycle(); cycle();

    for (int i = 0; i < NR; i++) chk($sformatf("final_r%0d", i), int'(env_mem[i]), int'(arch[i]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
